fb_fill: RTL and testbench

FB_FILL -- requirements
Module: fb_fill

---
 rtl/fb_fill.sv | 145 ++++++++++++++
 tb/tb_fb_fill.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fill.sv
// Rectangle fill engine: clips a command rectangle to the H x V framebuffer and streams
// one pixel write per unstalled cycle. Define FB_FILL_CHECKER_EN for checkerboard fill data.
module fb_fill #(
  parameter int H = 640,
  parameter int V = 480
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  input  logic [7:0]  color,
  output logic        busy,
  output logic        done,
  output logic        fb_wr,
  output logic [31:0] fb_addr,
  output logic [7:0]  fb_data,
  input  logic        fb_stall
);

  localparam logic [10:0] H_W  = 11'(H);
  localparam logic [10:0] V_W  = 11'(V);
  localparam logic [31:0] H_32 = 32'(H);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

  state_t      state_q;
  logic [9:0]  x0_q, y0_q, w_q, h_q;
  logic [7:0]  color_q;
  logic [10:0] xe_q, ye_q, x_q, y_q;
  logic [31:0] row_base_q;

  logic [10:0] x_sum_s, y_sum_s, xe_s, ye_s, x_inc_s, y_inc_s, nx_s, ny_s;
  logic        degen_s, row_end_s, last_s;
  logic [31:0] row0_s, next_addr_s;
  logic [7:0]  first_data_s, next_data_s;

  // Clip arithmetic and next-pixel stepping; the only multiply is the CLIP row base.
  always_comb begin
    x_sum_s     = {1'b0, x0_q} + {1'b0, w_q};
    y_sum_s     = {1'b0, y0_q} + {1'b0, h_q};
    xe_s        = (x_sum_s > H_W) ? H_W : x_sum_s;
    ye_s        = (y_sum_s > V_W) ? V_W : y_sum_s;
    degen_s     = (w_q == 10'd0) || (h_q == 10'd0) ||
                  ({1'b0, x0_q} >= H_W) || ({1'b0, y0_q} >= V_W);
    row0_s      = {22'd0, y0_q} * H_32;
    x_inc_s     = x_q + 11'd1;
    y_inc_s     = y_q + 11'd1;
    row_end_s   = (x_inc_s == xe_q);
    last_s      = row_end_s && (y_inc_s == ye_q);
    nx_s        = row_end_s ? {1'b0, x0_q} : x_inc_s;
    ny_s        = row_end_s ? y_inc_s : y_q;
    next_addr_s = row_end_s ? (row_base_q + H_32 + {22'd0, x0_q}) : (fb_addr + 32'd1);
`ifdef FB_FILL_CHECKER_EN
    first_data_s = (x0_q[0] ^ y0_q[0]) ? ~color_q : color_q;
    next_data_s  = (nx_s[0] ^ ny_s[0]) ? ~color_q : color_q;
`else
    first_data_s = color_q;
    next_data_s  = color_q;
`endif
  end

  // Command FSM with registered write port, busy and done.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      x0_q       <= 10'd0;
      y0_q       <= 10'd0;
      w_q        <= 10'd0;
      h_q        <= 10'd0;
      color_q    <= 8'd0;
      xe_q       <= 11'd0;
      ye_q       <= 11'd0;
      x_q        <= 11'd0;
      y_q        <= 11'd0;
      row_base_q <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fb_wr      <= 1'b0;
      fb_addr    <= 32'd0;
      fb_data    <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            w_q     <= w;
            h_q     <= h;
            color_q <= color;
            state_q <= S_CLIP;
            busy    <= 1'b1;
          end
        end
        S_CLIP: begin
          xe_q <= xe_s;
          ye_q <= ye_s;
          if (degen_s) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            state_q    <= S_FILL;
            x_q        <= {1'b0, x0_q};
            y_q        <= {1'b0, y0_q};
            row_base_q <= row0_s;
            fb_wr      <= 1'b1;
            fb_addr    <= row0_s + {22'd0, x0_q};
            fb_data    <= first_data_s;
          end
        end
        S_FILL: begin
          // A stalled write keeps every output frozen until it is accepted.
          if (!fb_stall) begin
            if (last_s) begin
              state_q <= S_DONE;
              fb_wr   <= 1'b0;
              done    <= 1'b1;
            end else begin
              x_q     <= nx_s;
              y_q     <= ny_s;
              fb_addr <= next_addr_s;
              fb_data <= next_data_s;
              if (row_end_s) begin
                row_base_q <= row_base_q + H_32;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          fb_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fill.sv
// Scoreboard bench for fb_fill: a rectangle model pushes expected writes, a monitor checks them.
module tb_fb_fill;
  localparam int H = 640;
  localparam int V = 480;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [9:0]  x0 = 10'd0, y0 = 10'd0, w = 10'd0, h = 10'd0;
  logic [7:0]  color = 8'd0;
  logic        fb_stall = 1'b0;
  logic        busy, done, fb_wr;
  logic [31:0] fb_addr;
  logic [7:0]  fb_data;

  fb_fill #(.H(H), .V(V)) dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
    .busy(busy), .done(done), .fb_wr(fb_wr), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_stall(fb_stall)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct { int start_cyc; int n; } cmd_t;
  cmd_t        cmd_q[$];
  logic [39:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int stall_mode = 0;
  int dir_base = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] c, input int px, input int py);
`ifdef FB_FILL_CHECKER_EN
    return (((px ^ py) & 1) != 0) ? ~c : c;
`else
    return c;
`endif
  endfunction

  // Reference: every pixel of the clipped rectangle in raster order.
  task automatic push_model(input int ax, ay, aw, ah, input logic [7:0] ac, input int n_cyc);
    int xe, ye, n;
    xe = (ax + aw > H) ? H : ax + aw;
    ye = (ay + ah > V) ? V : ay + ah;
    n = 0;
    if (aw != 0 && ah != 0 && ax < H && ay < V) begin
      for (int py = ay; py < ye; py++)
        for (int px = ax; px < xe; px++) begin
          exp_q.push_back({32'(py * H + px), pix(ac, px, py)});
          n++;
        end
    end
    cmd_q.push_back('{n_cyc, n});
  endtask

  // Monitor: compares accepted writes and done timing against the scoreboard.
  logic        prev_wr = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [7:0]  prev_data = 8'd0;
  int          stalls = 0;
  always @(negedge cpu_clk) begin
    logic [39:0] e;
    cmd_t c;
    if (!reset_n) begin
      prev_wr = 1'b0; prev_stall = 1'b0; stalls = 0;
    end else begin
      if (fb_wr) begin
        chk("addr_range", 32'(fb_addr < 32'(H * V)), 32'd1);
        if (prev_wr && prev_stall) begin
          chk("stall_hold_addr", fb_addr, prev_addr);
          chk("stall_hold_data", 32'(fb_data), 32'(prev_data));
        end
        if (!prev_wr && cmd_q.size() > 0)
          chk("first_write_latency", cyc, cmd_q[0].start_cyc + 2);
        if (fb_stall) stalls++;
        else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%0h expected=none (cycle %0d)", fb_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", fb_addr, e[39:8]);
          chk("write_data", 32'(fb_data), 32'(e[7:0]));
        end
      end
      if (done) begin
        chk("busy_at_done", 32'(busy), 32'd1);
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          c = cmd_q.pop_front();
          chk("done_cycle", cyc, c.start_cyc + 2 + c.n + stalls);
          chk("writes_left_at_done", exp_q.size(), 32'd0);
          exp_q.delete();
        end
        stalls = 0;
      end
      prev_wr = fb_wr; prev_stall = fb_stall; prev_addr = fb_addr; prev_data = fb_data;
    end
  end

  // Back-pressure driver: none, random, or a 3-cycle burst over the second write.
  always @(posedge cpu_clk) begin
    #1;
    case (stall_mode)
      1:       fb_stall = ($urandom_range(0, 2) == 0);
      2:       fb_stall = (cyc >= dir_base + 3) && (cyc <= dir_base + 5);
      default: fb_stall = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic issue(input int ax, ay, aw, ah, input logic [7:0] ac, output int n_cyc);
    x0 = 10'(ax); y0 = 10'(ay); w = 10'(aw); h = 10'(ah); color = ac;
    start = 1'b1;
    n_cyc = cyc;
    dir_base = cyc;
    push_model(ax, ay, aw, ah, ac, n_cyc);
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (cmd_q.size() > 0 && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none expected=done (cycle %0d)", cyc);
      cmd_q.delete(); exp_q.delete();
    end
    tick();
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int ax, ay, aw, ah;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_fb_wr", 32'(fb_wr), 32'd0);
    chk("reset_fb_addr", fb_addr, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    issue(10, 2, 3, 2, 8'hE0, n); wait_done();          // basic fill
    issue(638, 479, 5, 4, 8'h5A, n); wait_done();        // corner clip
    issue(5, 5, 0, 3, 8'h11, n); wait_done();            // w == 0
    issue(700, 5, 4, 3, 8'h22, n); wait_done();          // x0 beyond width
    issue(5, 480, 4, 3, 8'h33, n); wait_done();          // y0 beyond height
    issue(639, 0, 1023, 3, 8'h44, n); wait_done();       // single clipped column
    issue(0, 478, 1023, 1023, 8'h6C, n); wait_done();    // two full clipped rows

    stall_mode = 2;
    issue(10, 2, 3, 2, 8'hE0, n); wait_done();           // directed back-pressure
    stall_mode = 0;

    // start during FILL and in the done cycle must both be ignored
    issue(10, 2, 3, 2, 8'hE0, n);
    repeat (3) tick();
    x0 = 10'd0; y0 = 10'd0; w = 10'd5; h = 10'd5; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    chk("done_cycle_reached", cyc, n + 8);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("start_at_done_ignored", 32'(busy), 32'd0);
    repeat (3) tick();

    // reset during the fourth write abandons the command
    issue(10, 2, 3, 2, 8'hE0, n);
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_fb_wr", 32'(fb_wr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_addr", fb_addr, 32'd0);
    chk("rst_mid_data", 32'(fb_data), 32'd0);
    cmd_q.delete(); exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    issue(0, 0, 1, 1, 8'hC3, n); wait_done();

    for (int i = 0; i < 40; i++) begin
      ax = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 639);
      ay = ($urandom_range(0, 3) == 0) ? $urandom_range(460, 1023) : $urandom_range(0, 479);
      aw = $urandom_range(0, 12);
      ah = $urandom_range(0, 6);
      stall_mode = $urandom_range(0, 1);
      issue(ax, ay, aw, ah, 8'($urandom_range(0, 255)), n);
      wait_done();
    end
    stall_mode = 0;
    repeat (3) tick();
    chk("queues_empty", exp_q.size() + cmd_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
